ahb_slave_if_gen: RTL and testbench
===================================

AHB_SLAVE_IF_GEN -- requirements
Module: ahb_slave_if_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the data bus width (32 or 64).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 The block SHALL have parameter WAIT_STATES, default 0, range 0..15, meaning the fixed wait cycles inserted before each data-phase completion.
REQ-004 The block SHALL have parameter NUM_MASTERS, default 4, meaning the width of the hsplit vector; MID_W = clog2(NUM_MASTERS).
REQ-005 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-006 The ports SHALL be:
- hclk  in  1  bus clock.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  decoder select.
- haddr  in  ADDR_W  address-phase address.
- hwrite  in  1  1 = write, 0 = read.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwdata  in  DATA_W  data-phase write data.
- hready_in  in  1  bus-level ready.
- hmaster  in  MID_W  current master id from the arbiter.
- slv_rdata  in  DATA_W  read data from the slave core.
- slv_error  in  1  slave core flags an error on the current access.
- slv_split  in  1  slave core requests a split on the current access.
- slv_split_done  in  1  slave core is ready to resume the split master.
- slv_addr  out  ADDR_W  registered address to the core.
- slv_wdata  out  DATA_W  write data to the core.
- slv_wr  out  1  one-cycle write strobe.
- slv_rd  out  1  one-cycle read strobe.
- hrdata  out  DATA_W  read data to the master.
- hready  out  1  slave ready out.
- hresp  out  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- hsplit  out  NUM_MASTERS  one-hot split-release vector to the arbiter.

Function
REQ-007 The block SHALL accept a transfer only when hsel=1, htrans[1]=1 and hready_in=1 are sampled together on a hclk edge.
REQ-008 On acceptance the block SHALL register haddr, hwrite and hmaster, and SHALL drive slv_addr from that register.
REQ-009 The FSM SHALL have the states IDLE, WAIT, ACCESS, RESP1 and RESP2.
REQ-010 In IDLE, an accepted transfer SHALL move the FSM to WAIT when WAIT_STATES>0, or to ACCESS when WAIT_STATES=0.
REQ-011 In WAIT the block SHALL hold hready=0 and hresp=OKAY, and a down-counter SHALL leave WAIT for ACCESS after exactly WAIT_STATES cycles.
REQ-012 In ACCESS the block SHALL pulse slv_wr (with slv_wdata=hwdata) or slv_rd for one cycle, SHALL drive hready=1 and hresp=OKAY, and SHALL return hrdata=slv_rdata for reads and hrdata=0 for writes.
REQ-013 Total latency from address phase to completion SHALL be 1+WAIT_STATES cycles, so back-to-back zero-wait transfers complete every cycle.
REQ-014 A new transfer accepted while in ACCESS SHALL be pipelined into the next state without an idle cycle.
REQ-015 When slv_error=1 in ACCESS, the block SHALL enter RESP1 with hresp=ERROR and hready=0, then RESP2 with hresp=ERROR and hready=1, and SHALL then go to IDLE; strobes SHALL still fire.
REQ-016 When slv_split=1 in ACCESS, the block SHALL use the same two-cycle response with hresp=SPLIT, SHALL suppress slv_wr and slv_rd, and SHALL record the registered hmaster.
REQ-017 If slv_error and slv_split are both 1, slv_error SHALL take priority.
REQ-018 A pending split SHALL block a new split; a second slv_split SHALL be answered with a two-cycle RETRY instead.
REQ-019 slv_split_done with a split pending SHALL drive hsplit[recorded id]=1 for exactly one cycle and SHALL clear the pending flag.
REQ-020 slv_split_done with no split pending SHALL be ignored.
REQ-021 An htrans of IDLE or BUSY with hsel=1 SHALL complete with a zero-wait OKAY response, with no strobe and no state change.
REQ-022 When hsel=0, hrdata SHALL be 0.

Reset
REQ-023 While hreset=1, slv_addr, slv_wdata, hrdata and hresp SHALL be 0.
REQ-024 While hreset=1, slv_wr, slv_rd and hsplit SHALL be 0, hready SHALL be 1, the FSM SHALL be in IDLE, and the counter and pending-split flag SHALL be cleared.
REQ-025 Reset asserted mid-transfer or mid-split SHALL abort the transfer with no strobe and no hsplit pulse.

Structure
REQ-026 A shared package ahb_pkg SHALL hold the htrans and hresp encodings and the FSM state type.
REQ-027 One sub-module, ahb_wait_counter (load and down-count, done flag), SHALL be instantiated.

Verification
REQ-028 With WAIT_STATES=0, a NONSEQ write to 0x10 with data 0xDEADBEEF SHALL give slv_wr=1 the next cycle, slv_addr=0x10, hready=1 and hresp=00.
REQ-029 With WAIT_STATES=3, a read with slv_rdata=0x1234 SHALL hold hready=0 for 3 cycles, then give hready=1 and hrdata=0x1234.
REQ-030 slv_error during a read SHALL give hresp=01 for 2 cycles with hready 0 then 1.
REQ-031 slv_split from hmaster=2 SHALL give hresp=11 for 2 cycles; a later slv_split_done SHALL give hsplit=0100 for one cycle; a second slv_split in between SHALL give hresp=10.
REQ-032 Four back-to-back SEQ reads with WAIT_STATES=0 SHALL complete in 4 consecutive cycles.
REQ-033 hreset asserted during WAIT SHALL give hready=1, no strobe, and IDLE on the next edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and FSM state constants for the AHB slave interface.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_ACCESS = 3'd2;
  localparam state_t ST_RESP1  = 3'd3;
  localparam state_t ST_RESP2  = 3'd4;

endpackage

// File: rtl/ahb_slave_if_gen_if.sv
// AHB bus-side signal bundle between the fabric (master modport) and the slave interface.
interface ahb_slave_if_gen_if #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_MASTERS = 4
);
  localparam int MID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic                   hsel;
  logic [ADDR_W-1:0]      haddr;
  logic                   hwrite;
  logic [1:0]             htrans;
  logic [DATA_W-1:0]      hwdata;
  logic                   hready_in;
  logic [MID_W-1:0]       hmaster;
  logic [DATA_W-1:0]      hrdata;
  logic                   hready;
  logic [1:0]             hresp;
  logic [NUM_MASTERS-1:0] hsplit;

  modport slave (
    input  hsel, haddr, hwrite, htrans, hwdata, hready_in, hmaster,
    output hrdata, hready, hresp, hsplit
  );

  modport master (
    output hsel, haddr, hwrite, htrans, hwdata, hready_in, hmaster,
    input  hrdata, hready, hresp, hsplit
  );
endinterface

// File: rtl/ahb_wait_counter.sv
// Loadable down-counter; done marks the last wait cycle (count of one).
module ahb_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == ONE);
endmodule

// File: rtl/ahb_slave_if_gen.sv
// AHB slave interface: address-phase capture, fixed wait states, two-cycle
// ERROR/SPLIT/RETRY responses and single-entry split bookkeeping.
module ahb_slave_if_gen
  import ahb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int NUM_MASTERS = 4,
  localparam int MID_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                hclk,
  input  logic                hreset,
  ahb_slave_if_gen_if.slave   bus,
  input  logic [DATA_W-1:0]   slv_rdata,
  input  logic                slv_error,
  input  logic                slv_split,
  input  logic                slv_split_done,
  output logic [ADDR_W-1:0]   slv_addr,
  output logic [DATA_W-1:0]   slv_wdata,
  output logic                slv_wr,
  output logic                slv_rd
);
  localparam logic [3:0] WAIT_LD  = 4'(WAIT_STATES);
  localparam state_t     FIRST_ST = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [MID_W-1:0]  mid_q;
  logic [1:0]        resp_q, resp_d;
  logic              pend_q, pend_d;
  logic [MID_W-1:0]  sid_q, sid_d;
  logic              cnt_done;

  logic accept, core_stall, in_access, take, split_rel, strobe_ok;

  assign accept     = bus.hsel & bus.hready_in &
                      ((bus.htrans == HTRANS_NONSEQ) | (bus.htrans == HTRANS_SEQ));
  assign core_stall = slv_error | slv_split;
  assign in_access  = (state_q == ST_ACCESS);
  assign take       = accept & ((state_q == ST_IDLE) | (in_access & ~core_stall));
  assign split_rel  = pend_q & slv_split_done;

  ahb_wait_counter #(.CNT_W(4)) u_wait_cnt (
    .clk      (hclk),
    .rst      (hreset),
    .load     (take),
    .en       (state_q == ST_WAIT),
    .load_val (WAIT_LD),
    .done     (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    pend_d  = pend_q;
    sid_d   = sid_q;
    if (split_rel) pend_d = 1'b0;
    case (state_q)
      ST_IDLE:   if (take) state_d = FIRST_ST;
      ST_WAIT:   if (cnt_done) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (core_stall) begin
          state_d = ST_RESP1;
          if (slv_error)   resp_d = HRESP_ERROR;
          else if (pend_q) resp_d = HRESP_RETRY;
          else begin
            resp_d = HRESP_SPLIT;
            pend_d = 1'b1;
            sid_d  = mid_q;
          end
        end else if (take) state_d = FIRST_ST;
        else               state_d = ST_IDLE;
      end
      ST_RESP1:  state_d = ST_RESP2;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      mid_q   <= '0;
      resp_q  <= HRESP_OKAY;
      pend_q  <= 1'b0;
      sid_q   <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      pend_q  <= pend_d;
      sid_q   <= sid_d;
      if (take) begin
        addr_q  <= bus.haddr;
        write_q <= bus.hwrite;
        mid_q   <= bus.hmaster;
      end
    end
  end

  // A core error/split stretches the ACCESS cycle so the master never sees an OKAY completion.
  assign strobe_ok = in_access & ~(slv_split & ~slv_error) & ~hreset;
  assign slv_wr    = strobe_ok & write_q;
  assign slv_rd    = strobe_ok & ~write_q;
  assign slv_addr  = hreset ? '0 : addr_q;
  assign slv_wdata = hreset ? '0 : bus.hwdata;
  assign bus.hrdata = (!hreset && bus.hsel && in_access && !write_q) ? slv_rdata : '0;

  always_comb begin
    bus.hready = 1'b1;
    bus.hresp  = HRESP_OKAY;
    case (state_q)
      ST_WAIT:   bus.hready = 1'b0;
      ST_ACCESS: bus.hready = ~core_stall;
      ST_RESP1:  begin bus.hready = 1'b0; bus.hresp = resp_q; end
      ST_RESP2:  bus.hresp = resp_q;
      default:   ;
    endcase
    if (hreset) begin
      bus.hready = 1'b1;
      bus.hresp  = HRESP_OKAY;
    end
  end

  always_comb begin
    bus.hsplit = '0;
    if (split_rel && !hreset) bus.hsplit[sid_q] = 1'b1;
  end
endmodule

// File: tb/tb_ahb_slave_if_gen.sv
// Directed bench for ahb_slave_if_gen: a zero-wait instance and a three-wait instance.
module tb_ahb_slave_if_gen;
  import ahb_pkg::*;

  logic hclk = 1'b0;
  logic hreset;
  int vectors = 0;
  int miscompares = 0;

  always #5 hclk = ~hclk;

  ahb_slave_if_gen_if #(.DATA_W(32), .ADDR_W(32), .NUM_MASTERS(4)) b0 ();
  ahb_slave_if_gen_if #(.DATA_W(32), .ADDR_W(32), .NUM_MASTERS(4)) b3 ();
  assign b0.hready_in = b0.hready;
  assign b3.hready_in = b3.hready;

  logic [31:0] s0_rdata, s0_addr, s0_wdata, s3_rdata, s3_addr, s3_wdata;
  logic s0_error, s0_split, s0_done, s0_wr, s0_rd;
  logic s3_error, s3_split, s3_done, s3_wr, s3_rd;

  ahb_slave_if_gen #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(0), .NUM_MASTERS(4)) dut0 (
    .hclk(hclk), .hreset(hreset), .bus(b0),
    .slv_rdata(s0_rdata), .slv_error(s0_error), .slv_split(s0_split), .slv_split_done(s0_done),
    .slv_addr(s0_addr), .slv_wdata(s0_wdata), .slv_wr(s0_wr), .slv_rd(s0_rd)
  );

  ahb_slave_if_gen #(.DATA_W(32), .ADDR_W(32), .WAIT_STATES(3), .NUM_MASTERS(4)) dut3 (
    .hclk(hclk), .hreset(hreset), .bus(b3),
    .slv_rdata(s3_rdata), .slv_error(s3_error), .slv_split(s3_split), .slv_split_done(s3_done),
    .slv_addr(s3_addr), .slv_wdata(s3_wdata), .slv_wr(s3_wr), .slv_rd(s3_rd)
  );

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    b0.hsel = 1'b1; b0.haddr = 32'hABC; b0.hwrite = 1'b1; b0.htrans = HTRANS_NONSEQ;
    b0.hwdata = 32'h5A5A5A5A; b0.hmaster = '0;
    b3.hsel = 1'b1; b3.haddr = 32'hABC; b3.hwrite = 1'b0; b3.htrans = HTRANS_NONSEQ;
    b3.hwdata = 32'h0; b3.hmaster = '0;
    s0_rdata = 32'h77; s0_error = 0; s0_split = 0; s0_done = 1'b1;
    s3_rdata = 32'h77; s3_error = 0; s3_split = 0; s3_done = 0;
    cyc(); cyc(); #1;
    vectors++; if (b0.hready !== 1'b1) begin miscompares++; $display("FAIL rst_hready got=%0h want=1", b0.hready); end
    vectors++; if (b0.hresp !== 2'b00) begin miscompares++; $display("FAIL rst_hresp got=%0h want=0", b0.hresp); end
    vectors++; if ({s0_wr, s0_rd} !== 2'b00) begin miscompares++; $display("FAIL rst_strobes got=%0b want=00", {s0_wr, s0_rd}); end
    vectors++; if (b0.hsplit !== 4'b0000) begin miscompares++; $display("FAIL rst_hsplit got=%0b want=0000", b0.hsplit); end
    vectors++; if (s0_addr !== 32'h0) begin miscompares++; $display("FAIL rst_slv_addr got=%0h want=0", s0_addr); end
    vectors++; if (s0_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_slv_wdata got=%0h want=0", s0_wdata); end
    vectors++; if (b0.hrdata !== 32'h0) begin miscompares++; $display("FAIL rst_hrdata got=%0h want=0", b0.hrdata); end
    vectors++; if (b3.hready !== 1'b1) begin miscompares++; $display("FAIL rst_hready3 got=%0h want=1", b3.hready); end
    b0.htrans = HTRANS_IDLE; b3.htrans = HTRANS_IDLE; s0_done = 0;
    hreset = 1'b0;
    cyc();
    vectors++; if (s0_wr !== 1'b0) begin miscompares++; $display("FAIL rst_no_accept got=%0h want=0", s0_wr); end
  endtask

  task automatic test_write();
    b0.haddr = 32'h10; b0.hwrite = 1'b1; b0.htrans = HTRANS_NONSEQ; b0.hwdata = 32'h0;
    cyc();
    b0.htrans = HTRANS_IDLE; b0.hwdata = 32'hDEADBEEF; #1;
    vectors++; if (s0_wr !== 1'b1) begin miscompares++; $display("FAIL wr_strobe got=%0h want=1", s0_wr); end
    vectors++; if (s0_rd !== 1'b0) begin miscompares++; $display("FAIL wr_no_rd got=%0h want=0", s0_rd); end
    vectors++; if (s0_addr !== 32'h10) begin miscompares++; $display("FAIL wr_addr got=%0h want=10", s0_addr); end
    vectors++; if (s0_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_wdata got=%0h want=deadbeef", s0_wdata); end
    vectors++; if (b0.hready !== 1'b1) begin miscompares++; $display("FAIL wr_hready got=%0h want=1", b0.hready); end
    vectors++; if (b0.hresp !== 2'b00) begin miscompares++; $display("FAIL wr_hresp got=%0h want=0", b0.hresp); end
    vectors++; if (b0.hrdata !== 32'h0) begin miscompares++; $display("FAIL wr_hrdata got=%0h want=0", b0.hrdata); end
    cyc();
    vectors++; if (s0_wr !== 1'b0) begin miscompares++; $display("FAIL wr_one_pulse got=%0h want=0", s0_wr); end
  endtask

  task automatic test_wait_read();
    b3.haddr = 32'h20; b3.hwrite = 1'b0; b3.htrans = HTRANS_NONSEQ; s3_rdata = 32'h1234;
    cyc();
    b3.htrans = HTRANS_IDLE;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (b3.hready !== 1'b0) begin miscompares++; $display("FAIL wait_hready[%0d] got=%0h want=0", i, b3.hready); end
      vectors++; if (s3_rd !== 1'b0) begin miscompares++; $display("FAIL wait_no_rd[%0d] got=%0h want=0", i, s3_rd); end
      cyc();
    end
    #1;
    vectors++; if (b3.hready !== 1'b1) begin miscompares++; $display("FAIL wait_done_hready got=%0h want=1", b3.hready); end
    vectors++; if (s3_rd !== 1'b1) begin miscompares++; $display("FAIL wait_rd got=%0h want=1", s3_rd); end
    vectors++; if (b3.hrdata !== 32'h1234) begin miscompares++; $display("FAIL wait_hrdata got=%0h want=1234", b3.hrdata); end
    vectors++; if (s3_addr !== 32'h20) begin miscompares++; $display("FAIL wait_addr got=%0h want=20", s3_addr); end
    cyc();
    vectors++; if (s3_rd !== 1'b0) begin miscompares++; $display("FAIL wait_rd_one_pulse got=%0h want=0", s3_rd); end
  endtask

  task automatic test_error();
    b0.haddr = 32'h30; b0.hwrite = 1'b0; b0.htrans = HTRANS_NONSEQ; s0_rdata = 32'h55;
    cyc();
    b0.htrans = HTRANS_IDLE; s0_error = 1'b1; #1;
    vectors++; if (b0.hready !== 1'b0) begin miscompares++; $display("FAIL err_access_hready got=%0h want=0", b0.hready); end
    vectors++; if (s0_rd !== 1'b1) begin miscompares++; $display("FAIL err_rd_fires got=%0h want=1", s0_rd); end
    cyc();
    s0_error = 1'b0; #1;
    vectors++; if ({b0.hresp, b0.hready} !== 3'b010) begin miscompares++; $display("FAIL err_resp1 got=%0b want=010", {b0.hresp, b0.hready}); end
    cyc();
    vectors++; if ({b0.hresp, b0.hready} !== 3'b011) begin miscompares++; $display("FAIL err_resp2 got=%0b want=011", {b0.hresp, b0.hready}); end
    cyc();
    vectors++; if ({b0.hresp, b0.hready} !== 3'b001) begin miscompares++; $display("FAIL err_idle got=%0b want=001", {b0.hresp, b0.hready}); end
  endtask

  task automatic test_split();
    b0.hmaster = 2'd2; b0.haddr = 32'h40; b0.hwrite = 1'b1; b0.htrans = HTRANS_NONSEQ;
    cyc();
    b0.htrans = HTRANS_IDLE; s0_split = 1'b1; #1;
    vectors++; if (s0_wr !== 1'b0) begin miscompares++; $display("FAIL split_no_wr got=%0h want=0", s0_wr); end
    vectors++; if (b0.hready !== 1'b0) begin miscompares++; $display("FAIL split_access_hready got=%0h want=0", b0.hready); end
    cyc();
    s0_split = 1'b0; #1;
    vectors++; if ({b0.hresp, b0.hready} !== 3'b110) begin miscompares++; $display("FAIL split_resp1 got=%0b want=110", {b0.hresp, b0.hready}); end
    cyc();
    vectors++; if ({b0.hresp, b0.hready} !== 3'b111) begin miscompares++; $display("FAIL split_resp2 got=%0b want=111", {b0.hresp, b0.hready}); end
    cyc();
    b0.hmaster = 2'd1; b0.hwrite = 1'b0; b0.htrans = HTRANS_NONSEQ;
    cyc();
    b0.htrans = HTRANS_IDLE; s0_split = 1'b1; #1;
    vectors++; if (s0_rd !== 1'b0) begin miscompares++; $display("FAIL retry_no_rd got=%0h want=0", s0_rd); end
    cyc();
    s0_split = 1'b0; #1;
    vectors++; if ({b0.hresp, b0.hready} !== 3'b100) begin miscompares++; $display("FAIL retry_resp1 got=%0b want=100", {b0.hresp, b0.hready}); end
    cyc();
    vectors++; if ({b0.hresp, b0.hready} !== 3'b101) begin miscompares++; $display("FAIL retry_resp2 got=%0b want=101", {b0.hresp, b0.hready}); end
    cyc();
    vectors++; if (b0.hsplit !== 4'b0000) begin miscompares++; $display("FAIL split_hold got=%0b want=0000", b0.hsplit); end
    s0_done = 1'b1; #1;
    vectors++; if (b0.hsplit !== 4'b0100) begin miscompares++; $display("FAIL split_release got=%0b want=0100", b0.hsplit); end
    cyc();
    vectors++; if (b0.hsplit !== 4'b0000) begin miscompares++; $display("FAIL split_one_cycle got=%0b want=0000", b0.hsplit); end
    s0_done = 1'b0;
    b0.hmaster = 2'd3; b0.htrans = HTRANS_NONSEQ;
    cyc();
    b0.htrans = HTRANS_IDLE; s0_error = 1'b1; s0_split = 1'b1; #1;
    vectors++; if (s0_rd !== 1'b1) begin miscompares++; $display("FAIL prio_rd_fires got=%0h want=1", s0_rd); end
    cyc();
    s0_error = 1'b0; s0_split = 1'b0; #1;
    vectors++; if (b0.hresp !== 2'b01) begin miscompares++; $display("FAIL prio_resp got=%0h want=1", b0.hresp); end
    cyc(); cyc();
    b0.htrans = HTRANS_NONSEQ;
    cyc();
    b0.htrans = HTRANS_IDLE; s0_split = 1'b1;
    cyc();
    s0_split = 1'b0; #1;
    vectors++; if (b0.hresp !== 2'b11) begin miscompares++; $display("FAIL resplit_resp got=%0h want=3", b0.hresp); end
    cyc(); cyc();
    s0_done = 1'b1; hreset = 1'b1; #1;
    vectors++; if (b0.hsplit !== 4'b0000) begin miscompares++; $display("FAIL rst_split_hsplit got=%0b want=0000", b0.hsplit); end
    cyc();
    hreset = 1'b0; #1;
    vectors++; if (b0.hsplit !== 4'b0000) begin miscompares++; $display("FAIL rst_split_cleared got=%0b want=0000", b0.hsplit); end
    s0_done = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    b0.hwrite = 1'b0; b0.haddr = 32'h100; b0.htrans = HTRANS_NONSEQ;
    cyc();
    for (int i = 0; i < 4; i++) begin
      b0.haddr  = 32'(32'h104 + 4 * i);
      b0.htrans = (i < 3) ? HTRANS_SEQ : HTRANS_IDLE;
      s0_rdata  = 32'(32'hA000 + i);
      #1;
      vectors++; if (s0_rd !== 1'b1) begin miscompares++; $display("FAIL b2b_rd[%0d] got=%0h want=1", i, s0_rd); end
      vectors++; if (b0.hready !== 1'b1) begin miscompares++; $display("FAIL b2b_hready[%0d] got=%0h want=1", i, b0.hready); end
      vectors++; if (s0_addr !== 32'(32'h100 + 4 * i)) begin miscompares++; $display("FAIL b2b_addr[%0d] got=%0h want=%0h", i, s0_addr, 32'h100 + 4 * i); end
      vectors++; if (b0.hrdata !== 32'(32'hA000 + i)) begin miscompares++; $display("FAIL b2b_hrdata[%0d] got=%0h want=%0h", i, b0.hrdata, 32'hA000 + i); end
      cyc();
    end
    #1;
    vectors++; if (s0_rd !== 1'b0) begin miscompares++; $display("FAIL b2b_end got=%0h want=0", s0_rd); end
  endtask

  task automatic test_idle_busy();
    b0.hsel = 1'b1; b0.hwrite = 1'b1; b0.htrans = HTRANS_BUSY;
    cyc();
    vectors++; if ({s0_wr, s0_rd, b0.hready, b0.hresp} !== 5'b00100) begin miscompares++; $display("FAIL busy_resp got=%0b want=00100", {s0_wr, s0_rd, b0.hready, b0.hresp}); end
    b0.htrans = HTRANS_IDLE;
    cyc();
    vectors++; if ({s0_wr, b0.hready} !== 2'b01) begin miscompares++; $display("FAIL idle_resp got=%0b want=01", {s0_wr, b0.hready}); end
    b0.hsel = 1'b0; b0.hwrite = 1'b0; b0.htrans = HTRANS_NONSEQ; s0_rdata = 32'hFFFF;
    cyc();
    vectors++; if (s0_rd !== 1'b0) begin miscompares++; $display("FAIL nosel_no_rd got=%0h want=0", s0_rd); end
    vectors++; if (b0.hrdata !== 32'h0) begin miscompares++; $display("FAIL nosel_hrdata got=%0h want=0", b0.hrdata); end
    b0.htrans = HTRANS_IDLE;
  endtask

  task automatic test_reset_wait();
    b3.haddr = 32'h50; b3.hwrite = 1'b1; b3.htrans = HTRANS_NONSEQ; b3.hwdata = 32'h99;
    cyc();
    b3.htrans = HTRANS_IDLE; #1;
    vectors++; if (b3.hready !== 1'b0) begin miscompares++; $display("FAIL rw_in_wait got=%0h want=0", b3.hready); end
    hreset = 1'b1; #1;
    vectors++; if (b3.hready !== 1'b1) begin miscompares++; $display("FAIL rw_hready got=%0h want=1", b3.hready); end
    vectors++; if (s3_addr !== 32'h0) begin miscompares++; $display("FAIL rw_addr got=%0h want=0", s3_addr); end
    cyc();
    hreset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if ({s3_wr, b3.hready} !== 2'b01) begin miscompares++; $display("FAIL rw_after[%0d] got=%0b want=01", i, {s3_wr, b3.hready}); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_error();
    test_split();
    test_back_to_back();
    test_idle_busy();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
